instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 27 ++
 rtl/instr_fetch.sv | 133 +++++++++++++
 tb/tb_instr_fetch.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_if
// Brief   : ROM read port and decode-side instruction handshake of the fetch unit.
// Revision: 1.0 - initial release
// ============================================================================
interface instr_fetch_if;
  logic [31:0] rom_addr_o;
  logic        rom_cs_o;
  logic [1:0]  rom_hb_o;
  logic [31:0] rom_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  modport master (
    output rom_addr_o, rom_cs_o, rom_hb_o, instr_valid_o, instr_o, pc_o,
    input  rom_rdata_i, instr_ready_i
  );

  modport slave (
    input  rom_addr_o, rom_cs_o, rom_hb_o, instr_valid_o, instr_o, pc_o,
    output rom_rdata_i, instr_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch
// Brief   : Sequential instruction fetch into a 2-entry {pc, instr} buffer.
// Revision: 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic        clk_i,
  input  wire logic        rstn_i,
  input  wire logic        en_i,
  input  wire logic        flush_i,
  input  wire logic [31:0] flush_pc_i,
  output      logic        fault_o,
  instr_fetch_if.master    bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] pc_buf_q    [2];
  logic [31:0] instr_buf_q [2];

  logic fetch_active;
  logic flush_misaligned;
  logic push;
  logic pop;

  assign flush_misaligned = (flush_pc_i[1:0] != 2'b00);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      if (flush_misaligned) begin
        state_d = S_FAULT;
      end else begin
        state_d = en_i ? S_RUN : S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE:  if (en_i)  state_d = S_RUN;
        S_RUN:   if (!en_i) state_d = S_IDLE;
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    fetch_active = 1'b0;
    fault_o      = 1'b0;
    case (state_q)
      S_RUN:   fetch_active = 1'b1;
      S_FAULT: fault_o      = 1'b1;
      default: ;
    endcase
  end

  // A full buffer still accepts a fetch when the head leaves in the same cycle.
  assign pop  = bus.instr_valid_o & bus.instr_ready_i;
  assign push = fetch_active & ~flush_i & ((count_q < 2'd2) | pop);

  assign bus.rom_addr_o    = fetch_pc_q;
  assign bus.rom_cs_o      = push;
  assign bus.rom_hb_o      = 2'b11;
  assign bus.instr_valid_o = (count_q != 2'd0);
  assign bus.instr_o       = instr_buf_q[rd_ptr_q];
  assign bus.pc_o          = pc_buf_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (flush_i) begin
      fetch_pc_d = flush_pc_i;
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        pc_buf_q[i]    <= 32'd0;
        instr_buf_q[i] <= 32'd0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) begin
        pc_buf_q[wr_ptr_q]    <= fetch_pc_q;
        instr_buf_q[wr_ptr_q] <= bus.rom_rdata_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_fetch
// Brief   : Directed self-checking bench for instr_fetch; ROM word n holds n.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instr_fetch;
  logic        clk;
  logic        rstn;
  logic        en;
  logic        flush;
  logic [31:0] flush_pc;
  logic        fault;
  int          n_checks;
  int          n_err;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .en_i       (en),
    .flush_i    (flush),
    .flush_pc_i (flush_pc),
    .fault_o    (fault),
    .bus        (bus)
  );

  assign bus.rom_rdata_i = {2'b00, bus.rom_addr_o[31:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rstn     = 1'b0;
    en       = 1'b0;
    flush    = 1'b0;
    flush_pc = 32'd0;
    bus.instr_ready_i = 1'b0;
    #3;
    chk("rst_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    chk("rst_cs",    {31'd0, bus.rom_cs_o},      32'd0);
    chk("rst_fault", {31'd0, fault},             32'd0);
    chk("rst_instr", bus.instr_o,                32'd0);
    chk("rst_pc",    bus.pc_o,                   32'd0);
    chk("rst_hb",    {30'd0, bus.rom_hb_o},      32'd3);
    chk("rst_addr",  bus.rom_addr_o,             32'd0);
    tick();
    tick();

    // Sequential streaming with decode always ready.
    rstn = 1'b1;
    en   = 1'b1;
    bus.instr_ready_i = 1'b1;
    #1;
    chk("idle_cs", {31'd0, bus.rom_cs_o}, 32'd0);
    tick();
    for (int k = 0; k < 6; k++) begin
      chk("seq_addr", bus.rom_addr_o, 32'(4 * k));
      chk("seq_cs",   {31'd0, bus.rom_cs_o}, 32'd1);
      if (k > 0) begin
        chk("seq_valid", {31'd0, bus.instr_valid_o}, 32'd1);
        chk("seq_instr", bus.instr_o, 32'(k - 1));
        chk("seq_pc",    bus.pc_o,    32'(4 * (k - 1)));
      end else begin
        chk("seq_valid0", {31'd0, bus.instr_valid_o}, 32'd0);
      end
      tick();
    end

    // Back-pressure: buffer fills to two, fetching stops, head holds.
    bus.instr_ready_i = 1'b0;
    #1;
    chk("bp_cs_first", {31'd0, bus.rom_cs_o}, 32'd1);
    chk("bp_instr0",   bus.instr_o, 32'd5);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("bp_cs",    {31'd0, bus.rom_cs_o}, 32'd0);
      chk("bp_addr",  bus.rom_addr_o, 32'd28);
      chk("bp_instr", bus.instr_o, 32'd5);
      chk("bp_pc",    bus.pc_o, 32'd20);
      tick();
    end
    bus.instr_ready_i = 1'b1;
    #1;
    chk("full_pop_cs", {31'd0, bus.rom_cs_o}, 32'd1);
    for (int j = 0; j < 4; j++) begin
      chk("drain_instr", bus.instr_o, 32'(5 + j));
      chk("drain_pc",    bus.pc_o,    32'(20 + 4 * j));
      tick();
    end

    // Aligned redirect while full and popping.
    flush    = 1'b1;
    flush_pc = 32'h40;
    #1;
    chk("fl_cs",    {31'd0, bus.rom_cs_o}, 32'd0);
    chk("fl_valid", {31'd0, bus.instr_valid_o}, 32'd1);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_valid_after", {31'd0, bus.instr_valid_o}, 32'd0);
    chk("fl_addr",        bus.rom_addr_o, 32'h40);
    chk("fl_cs_after",    {31'd0, bus.rom_cs_o}, 32'd1);
    tick();
    chk("fl_pc",    bus.pc_o,    32'h40);
    chk("fl_instr", bus.instr_o, 32'h10);

    // Misaligned redirect enters FAULT; only an aligned flush leaves it.
    flush    = 1'b1;
    flush_pc = 32'h42;
    tick();
    flush = 1'b0;
    #1;
    chk("ft_fault", {31'd0, fault}, 32'd1);
    chk("ft_cs",    {31'd0, bus.rom_cs_o}, 32'd0);
    chk("ft_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    tick();
    chk("ft_sticky", {31'd0, fault}, 32'd1);
    chk("ft_cs2",    {31'd0, bus.rom_cs_o}, 32'd0);
    flush    = 1'b1;
    flush_pc = 32'h80;
    #1;
    chk("ft_pre_exit", {31'd0, fault}, 32'd1);
    tick();
    flush = 1'b0;
    #1;
    chk("ft_exit",  {31'd0, fault}, 32'd0);
    chk("ft_addr",  bus.rom_addr_o, 32'h80);
    chk("ft_cs_on", {31'd0, bus.rom_cs_o}, 32'd1);
    tick();
    chk("ft_pc",    bus.pc_o,    32'h80);
    chk("ft_instr", bus.instr_o, 32'h20);

    // Address wrap at the top of the space.
    flush    = 1'b1;
    flush_pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    #1;
    chk("wr_addr0", bus.rom_addr_o, 32'hFFFF_FFFC);
    chk("wr_cs0",   {31'd0, bus.rom_cs_o}, 32'd1);
    tick();
    chk("wr_addr1", bus.rom_addr_o, 32'h0000_0000);
    chk("wr_pc0",   bus.pc_o, 32'hFFFF_FFFC);
    chk("wr_ins0",  bus.instr_o, 32'h3FFF_FFFF);
    tick();
    chk("wr_pc1",   bus.pc_o, 32'h0000_0000);
    chk("wr_ins1",  bus.instr_o, 32'h0000_0000);

    // Disabling fetch stops pushes but the buffer still drains.
    bus.instr_ready_i = 1'b0;
    tick();
    en = 1'b0;
    #1;
    chk("dis_cs", {31'd0, bus.rom_cs_o}, 32'd0);
    tick();
    bus.instr_ready_i = 1'b1;
    #1;
    chk("dis_cs_idle", {31'd0, bus.rom_cs_o}, 32'd0);
    chk("dis_pc0",     bus.pc_o, 32'd0);
    tick();
    chk("dis_valid1",  {31'd0, bus.instr_valid_o}, 32'd1);
    chk("dis_pc1",     bus.pc_o, 32'd4);
    tick();
    chk("dis_empty",   {31'd0, bus.instr_valid_o}, 32'd0);

    // Asynchronous reset with two entries buffered.
    en = 1'b1;
    bus.instr_ready_i = 1'b0;
    tick();
    tick();
    tick();
    chk("ar_full_pc", bus.pc_o, 32'd8);
    chk("ar_full_cs", {31'd0, bus.rom_cs_o}, 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    chk("ar_instr", bus.instr_o, 32'd0);
    chk("ar_pc",    bus.pc_o, 32'd0);
    chk("ar_addr",  bus.rom_addr_o, 32'd0);
    chk("ar_hb",    {30'd0, bus.rom_hb_o}, 32'd3);
    #2;
    rstn = 1'b1;
    tick();
    chk("ar_refetch_addr", bus.rom_addr_o, 32'd0);
    chk("ar_refetch_cs",   {31'd0, bus.rom_cs_o}, 32'd1);
    tick();
    chk("ar_refetch_pc",    bus.pc_o, 32'd0);
    chk("ar_refetch_valid", {31'd0, bus.instr_valid_o}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
